// File: rtl/can_frame_receiver.sv
// Bit-level CAN receiver: destuffs a standard-ID frame, checks CRC-15 and fixed-form fields.
// Optional macro CAN_RX_ACK_DRIVE_EN enables a registered dominant ACK drive.
module can_frame_receiver #(
    parameter int IDLE_BITS = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [75:0] payload,
    output logic [3:0]  dlc,
    output logic        frame_valid,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic        ack_o
);
    typedef enum logic [3:0] {
        WAIT_IDLE, IDLE, ARB, CTRL, DATA, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF
    } state_t;

    localparam logic [1:0] ERR_STUFF = 2'b01;
    localparam logic [1:0] ERR_CRC   = 2'b10;
    localparam logic [1:0] ERR_FORM  = 2'b11;

    state_t      state_q, state_d;
    logic [6:0]  bit_idx_q, bit_idx_d;
    logic [2:0]  run_q, run_d;
    logic        last_q, last_d;
    logic [14:0] crc_q, crc_d;
    logic [14:0] crc_rx_q, crc_rx_d;
    logic [10:0] id_q, id_d;
    logic        rtr_q, rtr_d;
    logic [3:0]  dlc_sh_q, dlc_sh_d;
    logic [63:0] data_q, data_d;
    logic [75:0] payload_q, payload_d;
    logic [3:0]  dlc_q, dlc_d;
    logic        frame_valid_q, frame_valid_d;
    logic        err_valid_q, err_valid_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        busy_q, busy_d;

    logic        in_stuff, stuff_bit;
    logic [14:0] crc_next;
    logic [3:0]  nbytes, dlc_new;
    logic [6:0]  data_bits;
    logic [1:0]  err;

    // A bit after five equal bits is a stuff bit, including one trailing the CRC field.
    assign in_stuff  = (state_q inside {ARB, CTRL, DATA, CRC}) || (state_q == CRC_DEL);
    assign stuff_bit = in_stuff && (run_q == 3'd5);
    assign crc_next  = {crc_q[13:0], 1'b0} ^ ((rx ^ crc_q[14]) ? 15'h4599 : 15'h0000);
    assign nbytes    = (dlc_sh_q > 4'd8) ? 4'd8 : dlc_sh_q;
    assign data_bits = {nbytes, 3'b000};
    assign dlc_new   = {dlc_sh_q[2:0], rx};

    always_comb begin
        state_d       = state_q;
        bit_idx_d     = bit_idx_q;
        run_d         = run_q;
        last_d        = last_q;
        crc_d         = crc_q;
        crc_rx_d      = crc_rx_q;
        id_d          = id_q;
        rtr_d         = rtr_q;
        dlc_sh_d      = dlc_sh_q;
        data_d        = data_q;
        payload_d     = payload_q;
        dlc_d         = dlc_q;
        busy_d        = busy_q;
        frame_valid_d = 1'b0;
        err_valid_d   = 1'b0;
        err_code_d    = 2'b00;
        err           = 2'b00;

        if (stuff_bit) begin
            if (rx == last_q) begin
                err = ERR_STUFF;
            end else begin
                run_d  = 3'd1;
                last_d = rx;
            end
        end else begin
            if (state_q inside {ARB, CTRL, DATA, CRC}) begin
                run_d  = (rx == last_q) ? run_q + 3'd1 : 3'd1;
                last_d = rx;
            end
            case (state_q)
                WAIT_IDLE, IDLE: begin
                    if (state_q == IDLE || IDLE_BITS == 0) begin
                        if (!rx) begin
                            // SOF: feeding a dominant bit into a zero CRC leaves it zero.
                            state_d   = ARB;
                            busy_d    = 1'b1;
                            crc_d     = 15'd0;
                            run_d     = 3'd1;
                            last_d    = 1'b0;
                            bit_idx_d = 7'd0;
                            id_d      = 11'd0;
                            rtr_d     = 1'b0;
                            dlc_sh_d  = 4'd0;
                            data_d    = 64'd0;
                            crc_rx_d  = 15'd0;
                        end
                    end else if (rx) begin
                        bit_idx_d = bit_idx_q + 7'd1;
                        if (bit_idx_q + 7'd1 == 7'(IDLE_BITS)) begin
                            state_d   = IDLE;
                            bit_idx_d = 7'd0;
                        end
                    end else begin
                        bit_idx_d = 7'd0;
                    end
                end
                ARB: begin
                    crc_d     = crc_next;
                    bit_idx_d = bit_idx_q + 7'd1;
                    if (bit_idx_q < 7'd11) begin
                        id_d = {id_q[9:0], rx};
                    end else begin
                        rtr_d     = rx;
                        state_d   = CTRL;
                        bit_idx_d = 7'd0;
                    end
                end
                CTRL: begin
                    crc_d     = crc_next;
                    bit_idx_d = bit_idx_q + 7'd1;
                    if (bit_idx_q == 7'd0 && rx) begin
                        err = ERR_FORM;
                    end else if (bit_idx_q >= 7'd2) begin
                        dlc_sh_d = dlc_new;
                    end
                    if (bit_idx_q == 7'd5) begin
                        bit_idx_d = 7'd0;
                        state_d   = (rtr_q || dlc_new == 4'd0) ? CRC : DATA;
                    end
                end
                DATA: begin
                    crc_d     = crc_next;
                    bit_idx_d = bit_idx_q + 7'd1;
                    data_d[6'd63 - bit_idx_q[5:0]] = rx;
                    if (bit_idx_q == data_bits - 7'd1) begin
                        bit_idx_d = 7'd0;
                        state_d   = CRC;
                    end
                end
                CRC: begin
                    crc_rx_d  = {crc_rx_q[13:0], rx};
                    bit_idx_d = bit_idx_q + 7'd1;
                    if (bit_idx_q == 7'd14) begin
                        bit_idx_d = 7'd0;
                        state_d   = CRC_DEL;
                    end
                end
                CRC_DEL: begin
                    if (crc_rx_q != crc_q) err = ERR_CRC;
                    else if (!rx)          err = ERR_FORM;
                    else                   state_d = ACK_SLOT;
                end
                ACK_SLOT: state_d = ACK_DEL;
                ACK_DEL: begin
                    if (!rx) begin
                        err = ERR_FORM;
                    end else begin
                        state_d   = EOF;
                        bit_idx_d = 7'd0;
                    end
                end
                EOF: begin
                    if (!rx) begin
                        err = ERR_FORM;
                    end else if (bit_idx_q == 7'd6) begin
                        payload_d     = {rtr_q, id_q, data_q};
                        dlc_d         = dlc_sh_q;
                        frame_valid_d = 1'b1;
                        busy_d        = 1'b0;
                        state_d       = IDLE;
                        bit_idx_d     = 7'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 7'd1;
                    end
                end
                default: state_d = WAIT_IDLE;
            endcase
        end

        if (err != 2'b00) begin
            err_valid_d = 1'b1;
            err_code_d  = err;
            busy_d      = 1'b0;
            state_d     = WAIT_IDLE;
            bit_idx_d   = 7'd0;
        end
    end

`ifdef CAN_RX_ACK_DRIVE_EN
    logic ack_q, ack_d;
    // Low for the cycle in which the transmitter places the ACK slot bit on the line.
    assign ack_d = !(state_q == CRC_DEL && !stuff_bit && crc_rx_q == crc_q && rx);
    assign ack_o = ack_q;
`else
    assign ack_o = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= WAIT_IDLE;
            bit_idx_q     <= 7'd0;
            run_q         <= 3'd0;
            last_q        <= 1'b1;
            crc_q         <= 15'd0;
            crc_rx_q      <= 15'd0;
            id_q          <= 11'd0;
            rtr_q         <= 1'b0;
            dlc_sh_q      <= 4'd0;
            data_q        <= 64'd0;
            payload_q     <= 76'd0;
            dlc_q         <= 4'd0;
            frame_valid_q <= 1'b0;
            err_valid_q   <= 1'b0;
            err_code_q    <= 2'b00;
            busy_q        <= 1'b0;
`ifdef CAN_RX_ACK_DRIVE_EN
            ack_q         <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            run_q         <= run_d;
            last_q        <= last_d;
            crc_q         <= crc_d;
            crc_rx_q      <= crc_rx_d;
            id_q          <= id_d;
            rtr_q         <= rtr_d;
            dlc_sh_q      <= dlc_sh_d;
            data_q        <= data_d;
            payload_q     <= payload_d;
            dlc_q         <= dlc_d;
            frame_valid_q <= frame_valid_d;
            err_valid_q   <= err_valid_d;
            err_code_q    <= err_code_d;
            busy_q        <= busy_d;
`ifdef CAN_RX_ACK_DRIVE_EN
            ack_q         <= ack_d;
`endif
        end
    end

    assign payload     = payload_q;
    assign dlc         = dlc_q;
    assign frame_valid = frame_valid_q;
    assign err_valid   = err_valid_q;
    assign err_code    = err_code_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_can_frame_receiver.sv
// Directed bench for can_frame_receiver: a frame encoder with bit stuffing feeds vector
// tables and hand-built error, idle-gap and mid-frame reset sequences.
module tb_can_frame_receiver;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [75:0] payload;
    logic [3:0]  dlc;
    logic        frame_valid, err_valid, busy, ack_o;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    can_frame_receiver #(.IDLE_BITS(11)) dut (
        .clk(clk), .rst(rst), .rx(rx), .payload(payload), .dlc(dlc),
        .frame_valid(frame_valid), .err_valid(err_valid), .err_code(err_code),
        .busy(busy), .ack_o(ack_o)
    );

    typedef struct {
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic [75:0] exp_payload;
        logic [3:0]  exp_dlc;
    } vec_t;

    vec_t        vecs[6];
    int          n_cmp = 0, n_bad = 0;
    int          fv_cnt = 0, ev_cnt = 0, viol = 0;
    logic [1:0]  last_code = 2'b00;
    bit          fr_q[$];
    int          ack_idx;
    logic [75:0] exp_pl_last;
    logic [3:0]  exp_dlc_last;

    localparam logic [75:0] PL_123 = {1'b0, 11'h123, 64'h1122334455667788};

    task automatic check(input string name, input logic [75:0] got, input logic [75:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [14:0] crc_step(input logic [14:0] c, input bit b);
        logic fb;
        fb = b ^ c[14];
        c  = {c[13:0], 1'b0};
        if (fb) c = c ^ 15'h4599;
        return c;
    endfunction

    // bad: 0 clean, 1 flip CRC bit 0, 2 IDE=1, 3 EOF bit 3 dominant
    task automatic build(input logic [10:0] id, input logic rtr, input logic [3:0] dl,
                         input logic [63:0] data, input int bad);
        bit          raw[$];
        logic [14:0] crc;
        int          nb, run;
        bit          last;
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(bit'(bad == 2));
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dl[i]);
        nb = rtr ? 0 : ((dl > 4'd8) ? 8 : int'(dl));
        for (int i = 0; i < nb * 8; i++) raw.push_back(data[63 - i]);
        crc = 15'd0;
        foreach (raw[i]) crc = crc_step(crc, raw[i]);
        if (bad == 1) crc[0] = ~crc[0];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        fr_q.delete();
        last = 1'b1;
        run  = 0;
        foreach (raw[i]) begin
            fr_q.push_back(raw[i]);
            run  = (raw[i] == last) ? run + 1 : 1;
            last = raw[i];
            if (run == 5) begin
                fr_q.push_back(!last);
                last = !last;
                run  = 1;
            end
        end
        fr_q.push_back(1'b1);
        ack_idx = fr_q.size();
        fr_q.push_back(1'b0);
        fr_q.push_back(1'b1);
        for (int i = 0; i < 7; i++) fr_q.push_back(!(bad == 3 && i == 3));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic drive_frame(input bit exp_valid, input logic exp_busy,
                               input logic [75:0] exp_pl, input logic [3:0] exp_dl,
                               input string tag);
        int lows;
        bit at_slot;
        lows    = 0;
        at_slot = 1'b0;
        for (int i = 0; i < fr_q.size(); i++) begin
            @(negedge clk);
            if (i == 3) check({tag, " busy"}, busy, exp_busy);
            if (!ack_o) begin
                lows++;
                if (i == ack_idx) at_slot = 1'b1;
            end
            rx = fr_q[i];
        end
        @(negedge clk);
        rx = 1'b1;
        if (!ack_o) lows++;
        if (exp_valid) begin
            check({tag, " frame_valid"}, frame_valid, 1'b1);
            check({tag, " payload"}, payload, exp_pl);
            check({tag, " dlc"}, dlc, exp_dl);
            check({tag, " busy end"}, busy, 1'b0);
`ifdef CAN_RX_ACK_DRIVE_EN
            check({tag, " ack low cycles"}, lows, 1);
            check({tag, " ack at slot"}, at_slot, 1'b1);
`else
            check({tag, " ack low cycles"}, lows, 0);
`endif
            @(negedge clk);
            check({tag, " frame_valid pulse"}, frame_valid, 1'b0);
            exp_pl_last  = exp_pl;
            exp_dlc_last = exp_dl;
        end
    endtask

    task automatic err_frame(input int bad, input logic [1:0] code, input string tag);
        int fv0, ev0;
        fv0 = fv_cnt;
        ev0 = ev_cnt;
        build(11'h123, 1'b0, 4'd8, 64'h1122334455667788, bad);
        drive_frame(1'b0, 1'b1, 76'd0, 4'd0, tag);
        idle(12);
        check({tag, " err count"}, ev_cnt - ev0, 1);
        check({tag, " err_code"}, last_code, code);
        check({tag, " no valid"}, fv_cnt - fv0, 0);
        check({tag, " payload held"}, payload, exp_pl_last);
        check({tag, " dlc held"}, dlc, exp_dlc_last);
        check({tag, " busy"}, busy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (frame_valid) fv_cnt++;
            if (err_valid) begin
                ev_cnt++;
                last_code = err_code;
            end
            if (!err_valid && err_code != 2'b00) viol++;
`ifndef CAN_RX_ACK_DRIVE_EN
            if (ack_o !== 1'b1) viol++;
`endif
        end
    end

    initial begin
        int fv0, ev0;
        vecs[0] = '{11'h123, 1'b0, 4'd8,  64'h1122334455667788, PL_123, 4'd8};
        vecs[1] = '{11'h000, 1'b0, 4'd1,  64'h0000000000000000, 76'd0, 4'd1};
        vecs[2] = '{11'h7FF, 1'b1, 4'd4,  64'hDEADBEEF00000000, {1'b1, 11'h7FF, 64'h0}, 4'd4};
        vecs[3] = '{11'h2A5, 1'b0, 4'd2,  64'hABCD000000000000, {1'b0, 11'h2A5, 64'hABCD000000000000}, 4'd2};
        vecs[4] = '{11'h555, 1'b0, 4'd15, 64'h0102030405060708, {1'b0, 11'h555, 64'h0102030405060708}, 4'd15};
        vecs[5] = '{11'h0F0, 1'b0, 4'd0,  64'hFFFFFFFFFFFFFFFF, {1'b0, 11'h0F0, 64'h0}, 4'd0};

        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset payload", payload, 76'd0);
        check("reset dlc", dlc, 4'd0);
        check("reset frame_valid", frame_valid, 1'b0);
        check("reset err_valid", err_valid, 1'b0);
        check("reset err_code", err_code, 2'b00);
        check("reset busy", busy, 1'b0);
        check("reset ack_o", ack_o, 1'b1);
        rst = 1'b1;
        idle(11);

        for (int v = 0; v < 6; v++) begin
            build(vecs[v].id, vecs[v].rtr, vecs[v].dlc, vecs[v].data, 0);
            drive_frame(1'b1, 1'b1, vecs[v].exp_payload, vecs[v].exp_dlc, $sformatf("vec%0d", v));
            idle(12);
        end

        err_frame(1, 2'b10, "crc flip");

        // Stuff error: SOF plus six dominant bits; the error follows the sixth zero.
        fv0 = fv_cnt;
        ev0 = ev_cnt;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 6) begin
                check("stuff err_valid", err_valid, 1'b1);
                check("stuff err_code", err_code, 2'b01);
            end
            rx = 1'b0;
        end
        idle(10);
        build(11'h123, 1'b0, 4'd8, 64'h1122334455667788, 0);
        drive_frame(1'b0, 1'b0, 76'd0, 4'd0, "short gap");
        idle(12);
        check("short gap err count", ev_cnt - ev0, 1);
        check("short gap no valid", fv_cnt - fv0, 0);
        build(11'h123, 1'b0, 4'd8, 64'h1122334455667788, 0);
        drive_frame(1'b1, 1'b1, PL_123, 4'd8, "after gap");
        idle(12);

        err_frame(2, 2'b11, "ide form");
        err_frame(3, 2'b11, "eof form");

        // Reset in the middle of the data field.
        fv0 = fv_cnt;
        ev0 = ev_cnt;
        build(11'h555, 1'b0, 4'd15, 64'h0102030405060708, 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            rx = fr_q[i];
        end
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        @(negedge clk);
        check("midreset payload", payload, 76'd0);
        check("midreset dlc", dlc, 4'd0);
        check("midreset busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle(11);
        check("midreset no valid", fv_cnt - fv0, 0);
        check("midreset no err", ev_cnt - ev0, 0);
        build(11'h123, 1'b0, 4'd8, 64'h1122334455667788, 0);
        drive_frame(1'b1, 1'b1, PL_123, 4'd8, "post reset");
        idle(12);

        check("total valid pulses", fv_cnt, 8);
        check("total err pulses", ev_cnt, 4);
        check("err_code/ack idle violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/can_frame_receiver.md
Name: can_frame_receiver

Overview:
- Receive-side counterpart of the MOPS CAN frame serializer.
- Samples a serial CAN bit stream at one bit per clk and removes stuff bits.
- Decodes a standard (11-bit ID) data or remote frame and checks CRC-15 and the fixed-form fields.
- Presents the result in the same 76-bit payload packing the serializer consumes, with a one-cycle valid pulse. Used in MOPSHUB loopback benches and as a bit-level RX front end.

Parameters:
- IDLE_BITS, 11, number of consecutive recessive bits required before a SOF is accepted. 0 means SOF is accepted immediately after reset or error.

Ports:
- clk  in  1  bit clock; one CAN bit per rising edge
- rst  in  1  reset, asynchronous, active-low
- rx  in  1  serial CAN bit; 1 = recessive, 0 = dominant
- payload  out  76  [75]=RTR, [74:64]=ID, [63:0]=data
- dlc  out  4  received DLC field, raw value
- frame_valid  out  1  one-cycle pulse when a frame completes without error
- err_valid  out  1  one-cycle pulse on a detected error
- err_code  out  2  01 stuff, 10 CRC, 11 form; 00 when err_valid=0
- busy  out  1  high from SOF until frame end or error
- ack_o  out  1  ACK drive, active-low; see Optional Feature

Behaviour:
- Reset, as decided: rst asynchronous active-low, clk rising edge.
- Reset values: payload=0, dlc=0, frame_valid=0, err_valid=0, err_code=0, busy=0, ack_o=1, FSM=WAIT_IDLE, all counters cleared.
- Reset mid-frame discards the partial frame. No valid or error pulse is produced.
- rx is sampled on every posedge clk. No synchronizer is included; the source is synchronous.
- FSM states: WAIT_IDLE, IDLE, ARB, CTRL, DATA, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF.
- WAIT_IDLE counts consecutive rx=1; a 0 restarts the count. Go to IDLE when count reaches IDLE_BITS.
- IDLE: rx=0 is SOF. Go to ARB, set busy, seed CRC=0, feed SOF into the CRC.
- ARB: 11 ID bits MSB first, then RTR.
- CTRL: IDE, r0, then 4 DLC bits MSB first. IDE=1 is a form error; r0 is ignored.
- Data byte count = min(DLC,8). If RTR=1 or the count is 0, skip DATA.
- DATA: bytes MSB first. First byte goes to data[63:56], the next to [55:48], and so on. Unreceived bytes read 0.
- CRC state: 15 bits received, compared against the computed CRC.
- CRC-15: polynomial 0x4599, init 0, computed over destuffed bits from SOF through the last data bit.
- Destuffing applies from SOF through the last CRC bit:
  - After 5 consecutive equal bits, the next bit is a stuff bit and is discarded.
  - A stuff bit equal to the previous bit is a stuff error.
  - A stuff bit restarts the run count at 1 with its own value.
- CRC_DEL must be 1, else form error. The CRC mismatch check is made here; a mismatch is a CRC error, taking priority over a form error in the same bit.
- ACK_SLOT: either value accepted.
- ACK_DEL must be 1, else form error.
- EOF: 7 bits, each must be 1, else form error.
- Completion: on the cycle after the 7th EOF bit is sampled:
  - payload and dlc update,
  - frame_valid=1 for one cycle,
  - busy=0.
  - Then go to IDLE; the 3-bit intermission is not enforced.
- Error: err_valid=1 for one cycle with err_code, on the cycle after the offending bit.
  - payload and dlc hold their previous values.
  - busy=0, go to WAIT_IDLE.
- payload and dlc change only on frame_valid.
- Latency: frame_valid follows the last EOF bit by exactly 1 clk.
- Counters: 7-bit bit index, 3-bit run length, 15-bit CRC shift register; no wrap within a legal frame.

Optional Feature:
- Macro: CAN_RX_ACK_DRIVE_EN.
- Defined:
  - ack_o=0 for exactly the ACK_SLOT bit time when the CRC check passed; otherwise ack_o=1.
  - ack_o is registered so its low period aligns with the sampled ACK slot bit of a clk-synchronous transmitter.
- Undefined: ack_o is tied to 1 and the ACK logic is absent.

Test Plan:
1. ID=0x123, data=0x1122334455667788, DLC=8, RTR=0, IDLE_BITS=11 pre-idle -> frame_valid once; payload=0x0_123_1122334455667788 ([75]=RTR=0); dlc=8; err_valid never.
2. Same frame with one CRC bit flipped (stuffing recomputed) -> err_valid with err_code=10; payload unchanged; busy=0.
3. ID=0x000 data frame (forces stuffing); then a separate run injecting 6 consecutive dominant bits in ARB -> first run frame_valid with correct ID; second run err_code=01, and the receiver needs 11 recessive bits before the next SOF is accepted.
4. RTR=1, ID=0x7FF, DLC=4 -> payload[75]=1, [74:64]=0x7FF, data=0, dlc=4; DATA skipped.
5. DLC=2, data bytes 0xAB,0xCD; then DLC=15 with 8 bytes -> first: data=0xABCD000000000000; second: 8 bytes decoded, dlc=15.
6. rst pulsed low mid-DATA, then a clean frame -> no valid/error pulse for the aborted frame; the clean frame decodes correctly. With CAN_RX_ACK_DRIVE_EN, ack_o is low exactly 1 clk at the ACK slot of the clean frame.
